// File: rtl/cnn_pkg.sv
// Shared defaults, FSM state encoding and window-count helper for the CNN window sequencer.
package cnn_pkg;

  localparam int IMG_W_DEF  = 28;
  localparam int IMG_H_DEF  = 28;
  localparam int K_DEF      = 5;
  localparam int PIX_W_DEF  = 8;
  localparam int STRIDE_DEF = 1;
  localparam int ADDR_W_DEF = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT,
    S_ADVANCE,
    S_DONE
  } state_t;

  function automatic int win_count(input int img_h, input int img_w, input int k, input int stride);
    return ((img_h - k) / stride + 1) * ((img_w - k) / stride + 1);
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Scan and fetch counters for the window sequencer: window origin (row,col), pixel offset (i,j),
// RAM address generation and the last-pixel / last-window flags.
module window_addr_gen
  import cnn_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int K      = K_DEF,
  parameter int STRIDE = STRIDE_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SW     = $clog2(K * K + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_in,
  output logic [ADDR_W-1:0] addr,
  output logic [SW-1:0]     slot,
  output logic [4:0]        row,
  output logic [4:0]        col,
  output logic              reads_done,
  output logic              last_window
);

  localparam int KW = $clog2(K + 1);

  logic [KW-1:0]     i_q, i_d, j_q, j_d;
  logic [4:0]        row_q, row_d, col_q, col_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              last_pixel;

  assign last_pixel  = (i_q == KW'(K - 1)) && (j_q == KW'(K - 1));
  assign last_window = (int'(row_q) + STRIDE > IMG_H - K) && (int'(col_q) + STRIDE > IMG_W - K);
  assign addr        = base_q + (ADDR_W'(row_q) + ADDR_W'(i_q)) * ADDR_W'(IMG_W)
                     + ADDR_W'(col_q) + ADDR_W'(j_q);
  assign slot        = SW'(i_q) * SW'(K) + SW'(j_q);
  assign row         = row_q;
  assign col         = col_q;
  assign reads_done  = done_q;

  // Start clears everything and latches the frame base; advance steps the window origin.
  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    row_d  = row_q;
    col_d  = col_q;
    done_d = done_q;
    base_d = base_q;
    if (clear) begin
      i_d    = '0;
      j_d    = '0;
      row_d  = '0;
      col_d  = '0;
      done_d = 1'b0;
      base_d = base_in;
    end else if (advance) begin
      i_d    = '0;
      j_d    = '0;
      done_d = 1'b0;
      if (int'(col_q) + STRIDE > IMG_W - K) begin
        col_d = '0;
        row_d = row_q + 5'(STRIDE);
      end else begin
        col_d = col_q + 5'(STRIDE);
      end
    end else if (step) begin
      if (last_pixel) begin
        done_d = 1'b1;
      end else if (j_q == KW'(K - 1)) begin
        j_d = '0;
        i_d = i_q + KW'(1);
      end else begin
        j_d = j_q + KW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q    <= '0;
      j_q    <= '0;
      row_q  <= '0;
      col_q  <= '0;
      done_q <= 1'b0;
      base_q <= '0;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      row_q  <= row_d;
      col_q  <= col_d;
      done_q <= done_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/cnn_window_sequencer.sv
// KxK sliding-window feeder: fetches each window from pixel RAM and presents it over valid/ready.
// Holds the control FSM, the window capture register and the output handshake.
module cnn_window_sequencer
  import cnn_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int K      = K_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int STRIDE = STRIDE_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [ADDR_W-1:0]    IMG_BASE,
  output logic                 MEM_RDEN,
  output logic [ADDR_W-1:0]    MEM_ADDR,
  input  logic [PIX_W-1:0]     MEM_RDATA,
  output logic                 WIN_VALID,
  input  logic                 WIN_READY,
  output logic [K*K*PIX_W-1:0] WIN_DATA,
  output logic [4:0]           WIN_ROW,
  output logic [4:0]           WIN_COL,
  output logic                 WIN_LAST,
  output logic                 BUSY,
  output logic                 FRAME_DONE
);

  localparam int SW = $clog2(K * K + 1);
  localparam int WW = K * K * PIX_W;

  state_t            state_q, state_d;
  logic              rd_pend_q, rd_pend_d;
  logic [SW-1:0]     cap_slot_q, cap_slot_d;
  logic [WW-1:0]     win_q, win_d;
  logic              rden, start_acc, adv;
  logic [ADDR_W-1:0] gen_addr;
  logic [SW-1:0]     gen_slot;
  logic              reads_done, last_window;

  window_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .K      (K),
    .STRIDE (STRIDE),
    .ADDR_W (ADDR_W),
    .SW     (SW)
  ) u_addr_gen (
    .clk         (CLK),
    .rst         (RST),
    .clear       (start_acc),
    .step        (rden),
    .advance     (adv),
    .base_in     (IMG_BASE),
    .addr        (gen_addr),
    .slot        (gen_slot),
    .row         (WIN_ROW),
    .col         (WIN_COL),
    .reads_done  (reads_done),
    .last_window (last_window)
  );

  // FETCH is left only once the final datum lands, one cycle after the last read.
  always_comb begin
    state_d   = state_q;
    rden      = 1'b0;
    start_acc = 1'b0;
    adv       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d   = S_FETCH;
          start_acc = 1'b1;
        end
      end
      S_FETCH: begin
        rden = !reads_done;
        if (rd_pend_q && (cap_slot_q == SW'(K * K - 1))) state_d = S_PRESENT;
      end
      S_PRESENT: if (WIN_READY) state_d = S_ADVANCE;
      S_ADVANCE: begin
        if (last_window) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
          adv     = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (ABORT && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_comb begin
    rd_pend_d  = rden && !ABORT;
    cap_slot_d = gen_slot;
    win_d      = win_q;
    if (rd_pend_q) win_d[int'(cap_slot_q) * PIX_W +: PIX_W] = MEM_RDATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      rd_pend_q  <= 1'b0;
      cap_slot_q <= '0;
      win_q      <= '0;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      cap_slot_q <= cap_slot_d;
      win_q      <= win_d;
    end
  end

  assign MEM_RDEN   = rden;
  assign MEM_ADDR   = rden ? gen_addr : '0;
  assign WIN_VALID  = (state_q == S_PRESENT);
  assign WIN_DATA   = win_q;
  assign WIN_LAST   = WIN_VALID && last_window;
  assign BUSY       = (state_q != S_IDLE);
  assign FRAME_DONE = (state_q == S_DONE);

endmodule

// File: tb/tb_cnn_window_sequencer.sv
// Scoreboard bench for cnn_window_sequencer: stride-1 and stride-2 instances fed by byte-pattern RAMs.
module tb_cnn_window_sequencer;

  localparam int K      = 5;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 17;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int WW     = K * K * PIX_W;

  typedef struct {
    logic [WW-1:0] data;
    logic [4:0]    row;
    logic [4:0]    col;
    logic          last;
  } win_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, abort, win_ready;
  logic [ADDR_W-1:0] img_base;
  logic              mem_rden, win_valid, win_last, busy, frame_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata;
  logic [WW-1:0]     win_data;
  logic [4:0]        win_row, win_col;

  logic              start2, ready2;
  logic              mem_rden2, win_valid2, win_last2, busy2, frame_done2;
  logic [ADDR_W-1:0] mem_addr2;
  logic [PIX_W-1:0]  mem_rdata2;
  logic [WW-1:0]     win_data2;
  logic [4:0]        win_row2, win_col2;

  win_t exp_q[$];
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   total_cnt = 0;

  cnn_window_sequencer dut (
    .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .IMG_BASE(img_base),
    .MEM_RDEN(mem_rden), .MEM_ADDR(mem_addr), .MEM_RDATA(mem_rdata),
    .WIN_VALID(win_valid), .WIN_READY(win_ready), .WIN_DATA(win_data),
    .WIN_ROW(win_row), .WIN_COL(win_col), .WIN_LAST(win_last),
    .BUSY(busy), .FRAME_DONE(frame_done)
  );

  cnn_window_sequencer #(.STRIDE(2)) dut2 (
    .CLK(clk), .RST(rst), .START(start2), .ABORT(1'b0), .IMG_BASE(17'd0),
    .MEM_RDEN(mem_rden2), .MEM_ADDR(mem_addr2), .MEM_RDATA(mem_rdata2),
    .WIN_VALID(win_valid2), .WIN_READY(ready2), .WIN_DATA(win_data2),
    .WIN_ROW(win_row2), .WIN_COL(win_col2), .WIN_LAST(win_last2),
    .BUSY(busy2), .FRAME_DONE(frame_done2)
  );

  // Pixel RAM models: RAM[a] = a[7:0], one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rden)  mem_rdata  <= mem_addr[7:0];
    if (mem_rden2) mem_rdata2 <= mem_addr2[7:0];
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] exp_data(input logic [ADDR_W-1:0] b, input int r, input int c);
    logic [WW-1:0]     d;
    logic [ADDR_W-1:0] a;
    d = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        a = b + ADDR_W'((r + i) * IMG_W + c + j);
        d[(i * K + j) * PIX_W +: PIX_W] = a[PIX_W-1:0];
      end
    end
    return d;
  endfunction

  task automatic fill_queue(input logic [ADDR_W-1:0] b, input int stride);
    exp_q.delete();
    for (int r = 0; r <= IMG_H - K; r += stride) begin
      for (int c = 0; c <= IMG_W - K; c += stride) begin
        win_t w;
        w.data = exp_data(b, r, c);
        w.row  = 5'(r);
        w.col  = 5'(c);
        w.last = (r + stride > IMG_H - K) && (c + stride > IMG_W - K);
        exp_q.push_back(w);
      end
    end
  endtask

  // Runs one frame on the stride-1 instance; abort_at >= 0 aborts while that window is presented.
  task automatic run_frame(input logic [ADDR_W-1:0] b, input bit rand_ready, input int abort_at);
    int                cyc, got, dones;
    bit                seen_rden, seen_valid, fin;
    logic [ADDR_W-1:0] last_addr;
    win_t              w;
    fill_queue(b, 1);
    @(negedge clk);
    img_base = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    img_base = b ^ 17'h0A5A5;
    cyc = 1; got = 0; dones = 0; seen_rden = 0; seen_valid = 0; fin = 0; last_addr = '0;
    while (!fin && cyc < 40000) begin
      win_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_rden) begin
        if (!seen_rden) begin
          check("first_addr", mem_addr, b);
          seen_rden = 1;
        end
        last_addr = mem_addr;
      end
      if (frame_done) dones++;
      if (win_valid) begin
        if (!seen_valid) begin
          check("valid_latency", cyc, K * K + 2);
          seen_valid = 1;
          if (b == 0) begin
            check("first_pix_00", win_data[7:0], 8'h00);
            check("first_pix_44", win_data[199:192], 8'h74);
          end
        end
        if (exp_q.size() == 0) begin
          check("queue_underflow", exp_q.size(), 1);
          fin = 1;
        end else if (got == abort_at) begin
          win_ready = 1'b0;
          abort     = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          check("abort_valid", win_valid, 1'b0);
          check("abort_busy", busy, 1'b0);
          check("abort_done", frame_done, 1'b0);
          check("abort_dones_seen", dones, 0);
          fin = 1;
        end else begin
          w = exp_q[0];
          check("win_data", win_data, w.data);
          check("win_row", win_row, w.row);
          check("win_col", win_col, w.col);
          check("win_last", win_last, w.last);
          if (win_ready) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      if (!fin) begin
        if (!busy && cyc > 1) fin = 1;
        else begin
          @(negedge clk);
          cyc++;
        end
      end
    end
    check("frame_timeout", cyc < 40000, 1'b1);
    if (abort_at < 0) begin
      check("window_count", got, 576);
      check("queue_left", exp_q.size(), 0);
      check("frame_done_pulses", dones, 1);
      check("last_addr", last_addr, b + 17'd783);
    end
  endtask

  task automatic run_stride2();
    int cyc, got;
    win_t w;
    fill_queue('0, 2);
    ready2 = 1'b1;
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 1; got = 0;
    while (cyc < 10000 && (busy2 || cyc == 1)) begin
      if (win_valid2 && exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("s2_data", win_data2, w.data);
        check("s2_row", win_row2, w.row);
        check("s2_col", win_col2, w.col);
        check("s2_last", win_last2, w.last);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    check("s2_timeout", cyc < 10000, 1'b1);
    check("s2_window_count", got, 144);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; win_ready = 1'b0; img_base = '0;
    start2 = 1'b0; ready2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rden", mem_rden, 1'b0);
    check("rst_valid", win_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", win_data, '0);
    check("rst_rowcol", {win_row, win_col}, 10'd0);
    rst = 1'b0;

    $display("[TB] full frame, base 0, ready held high");
    run_frame(17'd0, 1'b0, -1);

    $display("[TB] busy START ignored, reset mid-fetch");
    @(negedge clk);
    img_base = '0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start    = 1'b1;
    img_base = 17'd5000;
    repeat (2) @(negedge clk);
    start = 1'b0;
    check("busy_start_addr", mem_addr, 17'd29);
    check("busy_start_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {mem_rden, mem_addr, win_valid, win_row, win_col, win_last, busy, frame_done},
          '0);
    check("midrst_data", win_data, '0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", busy, 1'b0);

    $display("[TB] full frame, base 784, random ready");
    run_frame(17'd784, 1'b1, -1);

    $display("[TB] stride 2 instance");
    run_stride2();

    $display("[TB] abort at window 100, then restart");
    run_frame(17'd0, 1'b0, 100);
    run_frame(17'd0, 1'b0, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
